// File: rtl/bit_serial_alu_seq.sv
// bit_serial_alu_seq
//   Runs a single 1-bit arithmetic slice (B-mux + full adder) over a WIDTH-bit
//   word, LSB first, one bit per clock. The carry lives in a flop between bits.
//   The full word result is presented with carry-out and signed overflow.
//
// Ports:
//   clk_i       clock, rising edge
//   rst_i       synchronous active-high reset; discards any operation in flight
//   start_i     request; accepted on an edge where ready_o=1
//   a_i, b_i    operands, sampled on the accept edge
//   sel_i       B-select (00=B, 01=~B, 10=0, 11=all-ones), sampled on accept
//   cin_i       carry into bit 0, sampled on accept
//   ready_o     high in IDLE only
//   busy_o      high in RUN
//   done_o      one-cycle completion pulse (DONE state)
//   result_o    completed sum, held until the next completion or reset
//   cout_o      carry out of bit WIDTH-1, held with result_o
//   ovf_o       carry into MSB XOR carry out of MSB, held with result_o
//   state_o     current FSM state (0=IDLE, 1=RUN, 2=DONE) for observation
//
// Handshake: a request is taken on any rising edge where start_i=1 and
// ready_o=1; start_i is ignored at all other times (no queuing). Each accepted
// request produces exactly one done_o pulse unless reset intervenes.
module bit_serial_alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [1:0]       sel_i,
  input  logic             cin_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [1:0]       sel_q;

  // 1-bit arithmetic slice acting on the current LSBs of the shift registers.
  logic bm;
  logic sum_bit;
  logic carry_nxt;

  always_comb begin
    bm = 1'b0;
    unique case (sel_q)
      2'b00:   bm = b_sr[0];
      2'b01:   bm = ~b_sr[0];
      2'b10:   bm = 1'b0;
      default: bm = 1'b1;
    endcase
    sum_bit   = a_sr[0] ^ bm ^ carry_q;
    carry_nxt = (a_sr[0] & bm) | (a_sr[0] & carry_q) | (bm & carry_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      sel_q    <= 2'b00;
      result_o <= '0;
      cout_o   <= 1'b0;
      ovf_o    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            a_sr    <= a_i;
            b_sr    <= b_i;
            sel_q   <= sel_i;
            carry_q <= cin_i;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at LSB.
          res_sr  <= {sum_bit, res_sr[WIDTH-1:1]};
          carry_q <= carry_nxt;
          if (cnt_q == LAST_IDX) begin
            result_o <= {sum_bit, res_sr[WIDTH-1:1]};
            cout_o   <= carry_nxt;
            // carry_q here is the carry into the MSB.
            ovf_o    <= carry_q ^ carry_nxt;
            cnt_q    <= '0;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Status outputs are pure decodes of the state flop.
  assign ready_o = (state_q == IDLE);
  assign busy_o  = (state_q == RUN);
  assign done_o  = (state_q == DONE);
  assign state_o = state_q;

endmodule

// File: doc/bit_serial_alu_seq.md
Name: bit_serial_alu_seq

Overview:
- Sequencer that runs one 1-bit arithmetic slice (B-mux plus full adder) over a WIDTH-bit word, LSB first, one bit per clock.
- Holds the carry in a flop between bits. Operands go into internal shift registers.
- Presents the full word result with carry-out and signed overflow.
- Serves as the area-minimal serial alternative to the ripple WIDTH-bit arithmetic unit and is used where throughput is not critical.

Parameters:
- WIDTH, 32, operand/result width in bits (>=2).
- CNT_W, $clog2(WIDTH), width of the bit-index counter.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  request; accepted only when ready_o=1.
- a_i  input  WIDTH  operand A, sampled on the accept edge.
- b_i  input  WIDTH  operand B, sampled on the accept edge.
- sel_i  input  2  B-select, sampled on the accept edge:
  - 00 = B
  - 01 = ~B
  - 10 = 0
  - 11 = all-ones
- cin_i  input  1  carry into bit 0, sampled on the accept edge.
- ready_o  output  1  high in IDLE only.
- busy_o  output  1  high in RUN.
- done_o  output  1  single-cycle completion pulse.
- result_o  output  WIDTH  completed sum; held until the next completion.
- cout_o  output  1  carry out of bit WIDTH-1; held with result_o.
- ovf_o  output  1  signed overflow (carry into MSB XOR carry out of MSB); held with result_o.

Behaviour:
- Reset (synchronous, overrides everything, including mid-RUN):
  - state=IDLE, counter=0, carry=0, shift regs=0.
  - ready_o=1, busy_o=0, done_o=0, result_o=0, cout_o=0, ovf_o=0.
  - An operation in flight is discarded with no done_o.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready_o=1.
  - On an edge with start_i=1: latch a_i, b_i, sel_i, and cin_i into the carry flop; counter<=0; go to RUN.
  - start_i=0: stay in IDLE.
- RUN (exactly WIDTH edges):
  - Each edge computes bit k = counter:
    - bm = mux(sel, b[0], ~b[0], 0, 1)
    - s = a[0]^bm^carry
    - carry <= maj(a[0], bm, carry)
  - s shifts into the result shift register MSB-side. A and B shift right.
  - On the edge with counter==WIDTH-1: capture carry-in-to-MSB for overflow, then go to DONE.
  - start_i is ignored throughout RUN; no queuing.
- DONE (one cycle):
  - done_o=1 during this cycle.
  - result_o, cout_o and ovf_o are updated on the edge that enters DONE and are valid while done_o=1.
  - ready_o=0 in DONE; the next edge returns to IDLE.
- Latency: accept edge E → done_o high in the cycle after edge E+WIDTH.
  - Accept-to-accept minimum is WIDTH+2 cycles.
- Output holding:
  - result_o, cout_o and ovf_o change only on DONE entry or reset. They do not clear on start.
  - sel_i and cin_i changes after accept have no effect on the running operation.
- Arithmetic identities (modulo 2^WIDTH):
  - sel=00 with cin: A+B+cin
  - sel=01 with cin=1: A−B; cout=1 means no borrow
  - sel=10: A+cin
  - sel=11 with cin=0: A−1
- The per-bit logic must match the existing 1-bit arithmetic slice exactly. Instantiating that slice is preferred.

Test Plan (WIDTH=8 override, plus one WIDTH=32 smoke run):
- Add, carry chain: sel=00, cin=0, A=0x0F, B=0x01 → result 0x10, cout=0, ovf=0. done_o is a single pulse in the cycle after edge E+8.
- Subtract with borrow: sel=01, cin=1, A=0x05, B=0x07 → result 0xFE, cout=0, ovf=0. Then A=0x07, B=0x05 → 0x02, cout=1.
- Increment/decrement wrap:
  - sel=10, cin=1, A=0xFF → 0x00, cout=1.
  - sel=11, cin=0, A=0x00 → 0xFF, cout=0.
  - sel=11, cin=0, A=0x01 → 0x00, cout=1.
- Signed overflow: sel=00, cin=0, A=0x7F, B=0x01 → 0x80, ovf=1, cout=0. Also A=0x80, B=0x80 → 0x00, ovf=1, cout=1.
- Start during busy: pulse start_i with new operands at RUN cycle 3 → ignored. The original result completes, and exactly one done_o occurs.
- Reset mid-RUN: assert rst_i at RUN cycle 4 → next cycle ready_o=1, result_o=0, cout_o=0, ovf_o=0, and no done_o. A fresh start then completes correctly.
